// File: rtl/bp_pkg.sv
// Shared types for the fetch-side branch predictor.
// - bp_ctr_e     : 2-bit saturating direction counter (SNT/WNT/WT/ST)
// - BP_CTR_RST   : counter value after reset
// - BP_CTR_ALLOC : counter value written when a taken branch allocates
// - bp_entry_t   : one table entry (valid, tag, counter, target)
// The tag field is sized for the widest tag any IDX_BITS/TAG_BITS split can
// produce; the top zero-extends its tag into it, so unused upper bits stay
// constant zero.
package bp_pkg;
  localparam int BP_TAG_MAX = 30;
  localparam int BP_TGT_W   = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e BP_CTR_RST   = WNT;
  localparam bp_ctr_e BP_CTR_ALLOC = WT;

  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_MAX-1:0] tag;
    bp_ctr_e               ctr;
    logic [BP_TGT_W-1:0]   target;
  } bp_entry_t;
endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating branch counter.
// Ports: cur (present state), taken (resolved outcome), nxt (next state).
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_ctr_e cur,
  input  logic    taken,
  output bp_ctr_e nxt
);
  logic [1:0] cur_v;
  assign cur_v = cur;

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST)  nxt = bp_ctr_e'(cur_v + 2'd1);
    end else begin
      if (cur != SNT) nxt = bp_ctr_e'(cur_v - 2'd1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table merged with
// a tagged target buffer, one entry per index.
// Ports:
//   clk, rst                  clock, async active-high reset
//   f_pc                      fetch PC to predict
//   pred_taken, pred_next_pc  zero-latency prediction for f_pc
//   ex_valid/pc/taken/target  resolved conditional branch from execute
//   ex_pred_taken             prediction that was made for it at fetch
//   mispredict, redirect_pc   redirect request to the PC unit
//   stat_branches/mispred     event counters (BP_STATS_EN), else tied to 0
// Optional feature macro: BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  bp_entry_t tbl [ENTRIES];

  logic [IDX_BITS-1:0]   f_idx, x_idx;
  logic [BP_TAG_MAX-1:0] f_tag, x_tag;
  bp_entry_t             f_ent, x_ent;
  logic                  f_hit, x_hit;
  bp_ctr_e               x_nxt;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign x_idx = ex_pc[IDX_BITS+1:2];
  assign f_tag = BP_TAG_MAX'(f_pc[TAG_HI:IDX_BITS+2]);
  assign x_tag = BP_TAG_MAX'(ex_pc[TAG_HI:IDX_BITS+2]);

  // Byte offset and PC bits above the tag do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], f_pc[31:TAG_HI+1], ex_pc[1:0], ex_pc[31:TAG_HI+1]};

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index shows up on the following cycle.
  assign f_ent        = tbl[f_idx];
  assign f_hit        = f_ent.valid && (f_ent.tag == f_tag);
  assign pred_taken   = !rst && f_hit && f_ent.ctr[1];
  assign pred_next_pc = pred_taken ? f_ent.target : f_pc + 32'd4;

  assign mispredict  = ex_valid && (ex_taken != ex_pred_taken);
  assign redirect_pc = !ex_valid ? 32'd0 : (ex_taken ? ex_target : ex_pc + 32'd4);

  assign x_ent = tbl[x_idx];
  assign x_hit = x_ent.valid && (x_ent.tag == x_tag);

  bp_sat_counter u_ctr (.cur(x_ent.ctr), .taken(ex_taken), .nxt(x_nxt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '{valid: 1'b0, tag: '0, ctr: BP_CTR_RST, target: '0};
    end else if (ex_valid) begin
      if (x_hit) begin
        tbl[x_idx].ctr <= x_nxt;
        if (ex_taken) tbl[x_idx].target <= ex_target;
      end else if (ex_taken) begin
        // Taken miss replaces whatever aliased into this index.
        tbl[x_idx] <= '{valid: 1'b1, tag: x_tag, ctr: BP_CTR_ALLOC, target: ex_target};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt, mp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (ex_valid   && br_cnt != '1) br_cnt <= br_cnt + 32'd1;
      if (mispredict && mp_cnt != '1) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign stat_branches = br_cnt;
  assign stat_mispred  = mp_cnt;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. Each step drives fetch/execute
// inputs at the falling edge, pushes the expected combinational results to a
// scoreboard and compares them 1 time unit later; table updates land on the
// following rising edge.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic        pt;
    logic [31:0] npc;
    logic        mp;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.nm, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e.pt});
    chk({e.nm, ".pred_next_pc"}, pred_next_pc, e.npc);
    chk({e.nm, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mp});
    chk({e.nm, ".redirect_pc"}, redirect_pc, e.rd);
  endtask

  task automatic step(input string nm, input logic [31:0] fpc,
                      input logic xv, input logic [31:0] xpc, input logic xt,
                      input logic [31:0] xtg, input logic xpt,
                      input logic e_pt, input logic [31:0] e_npc,
                      input logic e_mp, input logic [31:0] e_rd);
    @(negedge clk);
    f_pc = fpc; ex_valid = xv; ex_pc = xpc; ex_taken = xt;
    ex_target = xtg; ex_pred_taken = xpt;
    sb.push_back('{nm, e_pt, e_npc, e_mp, e_rd});
    #1;
    sb_check();
  endtask

  initial begin
    // Reset held: update presented during reset must be dropped.
    step("rst_hold", 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h104, 1, 32'h80);
    chk("rst.stat_branches", stat_branches, 32'd0);
    chk("rst.stat_mispred", stat_mispred, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    step("post_rst",   32'h100, 0, 0, 0, 0, 0,             0, 32'h104, 0, 32'h0);
    step("first_tk",   32'h100, 1, 32'h100, 1, 32'h80, 0,  0, 32'h104, 1, 32'h80);
    step("alloc_tk1",  32'h100, 1, 32'h100, 1, 32'h80, 1,  1, 32'h80,  0, 32'h80);
    step("tk2",        32'h100, 1, 32'h100, 1, 32'h80, 1,  1, 32'h80,  0, 32'h80);
    step("tk3",        32'h100, 1, 32'h100, 1, 32'h80, 1,  1, 32'h80,  0, 32'h80);
    step("nt1_st",     32'h100, 1, 32'h100, 0, 32'h80, 1,  1, 32'h80,  1, 32'h104);
    step("nt2_wt",     32'h100, 1, 32'h100, 0, 32'h80, 1,  1, 32'h80,  1, 32'h104);
    step("wnt",        32'h100, 0, 0, 0, 0, 0,             0, 32'h104, 0, 32'h0);
    step("nt_noalloc", 32'h200, 1, 32'h200, 0, 32'h999, 0, 0, 32'h204, 0, 32'h204);
    step("nt_miss",    32'h200, 0, 0, 0, 0, 0,             0, 32'h204, 0, 32'h0);
    // Retrain 0x100 to WT, then alias 0x200 (same idx, new tag) over it.
    step("retrain",    32'h100, 1, 32'h100, 1, 32'h80, 0,  0, 32'h104, 1, 32'h80);
    step("alias_wr",   32'h100, 1, 32'h200, 1, 32'h40, 0,  1, 32'h80,  1, 32'h40);
    step("alias_old",  32'h100, 0, 0, 0, 0, 0,             0, 32'h104, 0, 32'h0);
    step("alias_new",  32'h200, 0, 0, 0, 0, 0,             1, 32'h40,  0, 32'h0);
    step("same_cyc",   32'h300, 1, 32'h300, 1, 32'h500, 0, 0, 32'h304, 1, 32'h500);
    step("same_nxt",   32'h300, 0, 0, 0, 0, 0,             1, 32'h500, 0, 32'h0);

    // Reset asserted while an allocating update is presented.
    rst = 1'b1;
    step("rst_mid",    32'h404, 1, 32'h404, 1, 32'h900, 0, 0, 32'h408, 1, 32'h900);
    @(posedge clk); #1 rst = 1'b0;
    step("rst_drop",   32'h404, 0, 0, 0, 0, 0,             0, 32'h408, 0, 32'h0);
    step("rst_clear",  32'h300, 0, 0, 0, 0, 0,             0, 32'h304, 0, 32'h0);
    step("wrap",       32'hFFFF_FFFC, 0, 0, 0, 0, 0,       0, 32'h0,   0, 32'h0);

    // Five resolved branches, two mispredicted.
    step("st_a", 32'h600, 1, 32'h600, 1, 32'h700, 0, 0, 32'h604, 1, 32'h700);
    step("st_b", 32'h600, 1, 32'h600, 1, 32'h700, 1, 1, 32'h700, 0, 32'h700);
    step("st_c", 32'h600, 1, 32'h600, 1, 32'h700, 1, 1, 32'h700, 0, 32'h700);
    step("st_d", 32'h600, 1, 32'h600, 0, 32'h700, 1, 1, 32'h700, 1, 32'h604);
    step("st_e", 32'h600, 1, 32'h600, 1, 32'h720, 1, 1, 32'h700, 0, 32'h720);
    step("st_f", 32'h600, 0, 0, 0, 0, 0,             1, 32'h720, 0, 32'h0);

`ifdef BP_STATS_EN
    chk("stat_branches", stat_branches, 32'd5);
    chk("stat_mispred", stat_mispred, 32'd2);
    @(negedge clk);
    force dut.br_cnt = 32'hFFFF_FFFF;
    #1 release dut.br_cnt;
    step("sat_ev", 32'h600, 1, 32'h600, 1, 32'h720, 1, 1, 32'h720, 0, 32'h720);
    step("sat_idle", 32'h600, 0, 0, 0, 0, 0,            1, 32'h720, 0, 32'h0);
    chk("stat_sat", stat_branches, 32'hFFFF_FFFF);
`else
    chk("stat_branches_off", stat_branches, 32'd0);
    chk("stat_mispred_off", stat_mispred, 32'd0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor for the RV32I core. It predicts the outcome of conditional branches (beq/bne/blt/bge/bltu/bgeu) at fetch.
- It is trained by the execute-stage branch comparator's resolved outcome (BrTaken) and target. It also flags mispredictions so the PC unit can redirect.
- Direct-mapped branch history table (2-bit saturating counters) combined with a tagged branch target buffer.

Parameters:
- IDX_BITS, 6, log2 of table entries (64 entries).
- TAG_BITS, 8, tag width stored per entry.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- f_pc  input  32  fetch PC to predict.
- pred_taken  output  1  prediction for f_pc: 1 = taken.
- pred_next_pc  output  32  predicted next PC: BTB target if pred_taken, else f_pc+4.
- ex_valid  input  1  resolving instruction is a conditional branch (Branch).
- ex_pc  input  32  PC of the resolving branch.
- ex_taken  input  1  resolved outcome (BrTaken).
- ex_target  input  32  resolved taken target (PC+imm).
- ex_pred_taken  input  1  prediction made for this branch at fetch, carried down the pipeline.
- mispredict  output  1  ex_valid & (ex_taken != ex_pred_taken).
- redirect_pc  output  32  ex_taken ? ex_target : ex_pc+4; meaningful only when mispredict=1.
- stat_branches  output  32  resolved-branch count (BP_STATS_EN only).
- stat_mispred  output  32  misprediction count (BP_STATS_EN only).

Behaviour:
- Interface: one clock (clk), asynchronous active-high reset (rst).
- Address split:
  - idx = pc[IDX_BITS+1:2]
  - tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
  - pc[1:0] ignored.
- Entry contents: valid (1), tag (TAG_BITS), counter (2), target (32).
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. The counter predicts taken when bit[1]=1.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - pred_taken = hit & counter[1].
  - pred_next_pc = pred_taken ? target : f_pc+4, with 32-bit wrap-around (0xFFFFFFFC+4 = 0x00000000).
- mispredict and redirect_pc are combinational from the ex_* inputs. They are forced to 0 when ex_valid=0.
- Update on rising clk when ex_valid=1, using ex_pc's idx/tag:
  - Hit, ex_taken=1: counter saturating-increments (ST stays ST); target <= ex_target.
  - Hit, ex_taken=0: counter saturating-decrements (SNT stays SNT); target unchanged.
  - Miss, ex_taken=1: allocate (overwrite) the entry with valid=1, tag, target=ex_target, counter=WT.
  - Miss, ex_taken=0: no change; not-taken branches never allocate.
  - ex_valid=0: no state change.
- Simultaneous lookup and update of the same idx in one cycle: the lookup returns the pre-update entry. There is no write-to-read bypass; the new value is visible the next cycle.
- Aliasing: different PCs with equal idx and equal tag share an entry. This is accepted.
- Reset state (asynchronous):
  - All valid=0, counters=WNT, targets=0, stats=0.
  - Outputs during reset: pred_taken=0 and pred_next_pc=f_pc+4.
- Reset mid-operation: any update presented in a cycle where rst is asserted is dropped. Table state is cleared regardless of in-flight updates.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined:
  - stat_branches increments on each clock with ex_valid=1.
  - stat_mispred increments on each clock with mispredict=1.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- When undefined: both ports remain present and are tied to 0, with no counter flops.

Decomposition:
- Package bp_pkg holds:
  - the 2-bit counter enum (SNT/WNT/WT/ST);
  - the reset counter constant (WNT);
  - the allocation counter constant (WT);
  - the packed entry struct, parameterised by widths via localparams.
- One sub-module, bp_sat_counter: a combinational 2-bit saturating next-state function (inputs cur, taken; output nxt). The table itself stays inline.

Test Plan:
- Reset, then f_pc=0x100 -> pred_taken=0, pred_next_pc=0x104. Branch at 0x100 resolves taken to 0x80 -> mispredict=1, redirect_pc=0x80. Next cycle f_pc=0x100 -> pred_taken=1, pred_next_pc=0x80.
- Same branch resolved taken 3 more times, then not-taken once -> counter ST->WT, prediction still taken. A second not-taken gives WNT -> pred_taken=0.
- Not-taken first resolution of 0x200 on an empty table -> no allocation; f_pc=0x200 still yields pred_next_pc=0x204. mispredict=0 when ex_pred_taken=0.
- Alias: allocate 0x100. Then 0x100 + (1<<(IDX_BITS+2)) resolves taken -> entry overwritten with the new tag. 0x100 now misses -> pred_taken=0.
- Same-cycle lookup/update of idx for 0x300 (first taken) -> pred_taken=0 that cycle, 1 the following cycle. Asserting rst mid-update -> entry remains invalid after release.
- BP_STATS_EN defined: 5 branches with 2 mispredicts -> stat_branches=5, stat_mispred=2. Preloading a counter near saturation is not possible, so a forced value of 0xFFFFFFFF plus one more event must hold at 0xFFFFFFFF.
